pwm_capt: RTL and testbench
===========================

Name: pwm_capt

Overview:
- APB-slave PWM input decoder; the receive-side counterpart of the PTC PWM generator.
- Samples an external PWM waveform and measures its period and high time in PCLK cycles.
- Publishes each completed period and high-time pair atomically in registers and raises a level interrupt.
- Sits beside the PWM block on the peripheral APB segment; PWM_OUTn may loop back to pwm_in for self-test.

Parameters:
- CNT_W, 32: width of the measurement counter and of the PERIOD/HIGH registers (8..32).
- SYNC_STAGES, 2: number of synchronizer flops on pwm_in (>=2).
- FILT_LEN, 4: glitch-filter stability length in cycles; used only when the filter is compiled in.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous, active-high reset (one clock domain, sampled on posedge PCLK).
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PADDR  in  2  word address [3:2].
- PWRITE  in  1  APB write.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; combinational; 0 when no read access.
- pwm_in  in  1  asynchronous PWM input.
- INTcapt  out  1  level interrupt.

Behaviour:
- Register map (PADDR):
  - 00 CTRL, RW: [0] EN, [1] IE, [2] POL (invert pwm_in), [3] SINGLE.
  - 01 STATUS: [0] DONE (W1C), [1] OVR (W1C), [2] TMO (W1C), [5:4] state (RO).
  - 10 PERIOD, RO.
  - 11 HIGH, RO.
  - Unused bits read 0. Writes to RO registers are ignored.
- Access rules: write when PSEL&PWRITE&PENABLE; read when PSEL&~PWRITE&PENABLE; zero wait states.
- Reset: CTRL, STATUS, PERIOD, HIGH, the counter and the high-time shadow all clear to 0. State = IDLE, INTcapt=0, PRDATA=0.
- Input path: pwm_in passes through SYNC_STAGES flops, XOR POL, then one edge-detect flop. A rise or fall is flagged SYNC_STAGES+1 cycles after the pin edge.
- FSM, encoded as IDLE=0, WAIT_RISE=1, MEAS_HIGH=2, MEAS_LOW=3:
  - IDLE: go to WAIT_RISE when EN=1.
  - WAIT_RISE: on rise, cnt<=1 and go to MEAS_HIGH. The partial first period is discarded.
  - MEAS_HIGH: cnt++ each cycle; on fall, shadow<=cnt and go to MEAS_LOW.
  - MEAS_LOW: cnt++ each cycle; on rise, PERIOD<=cnt, HIGH<=shadow and DONE<=1, all in the same cycle. Then cnt<=1 and go to MEAS_HIGH.
  - If SINGLE=1, a completion instead clears CTRL.EN and goes to IDLE.
- Result: for a waveform high H cycles and low L cycles, PERIOD=H+L and HIGH=H exactly.
- OVR: set when a completion occurs while DONE is already 1. PERIOD and HIGH are still overwritten.
- Timeout: when cnt reaches 2^CNT_W-1 in MEAS_HIGH or MEAS_LOW:
  - TMO<=1, go to WAIT_RISE.
  - PERIOD and HIGH keep their values; cnt holds its value.
  - 0% and 100% duty therefore report TMO only.
- EN cleared mid-measurement: go to IDLE next cycle; partial data discarded; PERIOD, HIGH and STATUS retained.
- W1C to a STATUS bit in the same cycle as that bit's set event: the set wins.
- Writing CTRL while EN=1 takes effect next cycle. Changing POL while enabled may produce one spurious edge; software clears EN before changing POL.
- INTcapt = IE & (DONE | TMO), registered-free (combinational from flops).
- PRESET asserted mid-operation: everything returns to reset values on that edge.

Optional Feature:
- Macro: PWM_CAPT_FILTER_EN.
- Defined: a digital filter sits after the synchronizer and before POL. The filtered level changes only after the raw synchronized input has differed from it for FILT_LEN consecutive cycles. Pulses shorter than FILT_LEN are suppressed. Edge latency grows by FILT_LEN cycles. Measured PERIOD and HIGH are unchanged for clean inputs.
- Undefined: no filter; FILT_LEN is unused.

Decomposition:
- Package pwm_capt_pkg holds:
  - register address constants (ADDR_CTRL/STATUS/PERIOD/HIGH);
  - CTRL and STATUS bit indices;
  - state encoding constants.
- Sub-module pwm_capt_sync_filt contains the synchronizer, the optional filter, POL inversion and the edge detector. It outputs rise/fall pulses.
- The top level holds the APB decode, registers, FSM and counter.

Test Plan:
1. Reset, then read all four addresses -> all 0; INTcapt=0.
2. CTRL=0x3; drive pwm_in high 3 / low 7 repeatedly -> after the second rise, PERIOD=10, HIGH=3, DONE=1, INTcapt=1. Continue without clearing -> OVR=1 on the next completion.
3. CTRL=0x9 (SINGLE) with 25/75 cycles -> PERIOD=100, HIGH=25; CTRL.EN reads 0; state=IDLE; no further updates.
4. CNT_W=8; pwm_in held high after one rise -> TMO=1 after 254 further cycles; PERIOD/HIGH unchanged; state=WAIT_RISE.
5. Write STATUS=0x1 in the same cycle as a completion -> DONE remains 1. Clear EN mid-MEAS_LOW -> state=IDLE; PERIOD unchanged.
6. With PWM_CAPT_FILTER_EN and FILT_LEN=4: 2-cycle glitch pulses on a 10/10 waveform -> PERIOD=20, HIGH=10. Without the macro the same stimulus produces wrong values.

Source files
------------

// File: rtl/pwm_capt_pkg.sv
// Shared constants for the pwm_capt PWM input decoder: register map, bit fields, FSM states.
// The optional glitch filter is enabled with PWM_CAPT_FILTER_EN (see pwm_capt_sync_filt).
package pwm_capt_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_HIGH   = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IE     = 1;
  localparam int CTRL_POL    = 2;
  localparam int CTRL_SINGLE = 3;

  localparam int STAT_DONE = 0;
  localparam int STAT_OVR  = 1;
  localparam int STAT_TMO  = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } capt_state_t;

endpackage

// File: rtl/pwm_capt_sync_filt.sv
// Input conditioning for pwm_capt: synchronizer, optional glitch filter (PWM_CAPT_FILTER_EN),
// polarity inversion and edge detection producing one-cycle rise/fall pulses.
module pwm_capt_sync_filt
  import pwm_capt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic pwm_in,
  input  logic pol,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_raw;
  logic                   level;
  logic                   level_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign level_raw = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPT_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic          filt_q;
  logic [FW-1:0] stab_q;

  // The filtered level follows the raw level only after FILT_LEN consecutive differing samples.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else if (level_raw != filt_q) begin
      if (stab_q == FW'(FILT_LEN - 1)) begin
        filt_q <= level_raw;
        stab_q <= '0;
      end else begin
        stab_q <= stab_q + FW'(1);
      end
    end else begin
      stab_q <= '0;
    end
  end

  assign level = filt_q ^ pol;
`else
  localparam int unused_filt_len = FILT_LEN;

  assign level = level_raw ^ pol;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/pwm_capt.sv
// APB-slave PWM input decoder: measures period and high time of pwm_in in PCLK cycles.
// Build with PWM_CAPT_FILTER_EN to insert the glitch filter in the input path.
module pwm_capt
  import pwm_capt_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [1:0]  PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  input  logic        pwm_in,
  output logic        INTcapt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       ctrl_q;
  logic             done_q, ovr_q, tmo_q;
  logic [CNT_W-1:0] cnt_q, shadow_q, period_q, high_q;
  capt_state_t      state_q, state_d;

  logic rise, fall;
  logic wr_en, rd_en, wr_ctrl, wr_status;
  logic cnt_load, cnt_inc, cap_shadow, complete, timeout;
  logic clr_done, clr_ovr, clr_tmo;
  logic unused_pwdata;

  pwm_capt_sync_filt #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_sync_filt (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .pwm_in(pwm_in),
    .pol   (ctrl_q[CTRL_POL]),
    .rise  (rise),
    .fall  (fall)
  );

  assign wr_en     = PSEL & PWRITE & PENABLE;
  assign rd_en     = PSEL & ~PWRITE & PENABLE;
  assign wr_ctrl   = wr_en && (PADDR == ADDR_CTRL);
  assign wr_status = wr_en && (PADDR == ADDR_STATUS);
  assign clr_done  = wr_status & PWDATA[STAT_DONE];
  assign clr_ovr   = wr_status & PWDATA[STAT_OVR];
  assign clr_tmo   = wr_status & PWDATA[STAT_TMO];
  assign unused_pwdata = ^PWDATA[31:4];

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    cap_shadow = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    if (!ctrl_q[CTRL_EN]) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_RISE;
        WAIT_RISE: begin
          if (rise) begin
            cnt_load = 1'b1;
            state_d  = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            cap_shadow = 1'b1;
            cnt_inc    = (cnt_q != CNT_MAX);
            state_d    = MEAS_LOW;
          end else if (cnt_q == CNT_MAX) begin
            timeout = 1'b1;
            state_d = WAIT_RISE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            complete = 1'b1;
            cnt_load = 1'b1;
            state_d  = ctrl_q[CTRL_SINGLE] ? IDLE : MEAS_HIGH;
          end else if (cnt_q == CNT_MAX) begin
            timeout = 1'b1;
            state_d = WAIT_RISE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter, high-time shadow and the atomically published result pair.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      period_q <= '0;
      high_q   <= '0;
    end else begin
      if (cnt_load)     cnt_q <= CNT_W'(1);
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      if (cap_shadow) shadow_q <= cnt_q;
      if (complete) begin
        period_q <= cnt_q;
        high_q   <= shadow_q;
      end
    end
  end

  // Status set events take priority over a simultaneous write-one-to-clear.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_q <= '0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= PWDATA[3:0];
      if (complete && ctrl_q[CTRL_SINGLE]) ctrl_q[CTRL_EN] <= 1'b0;
      done_q <= complete | (done_q & ~clr_done);
      ovr_q  <= (complete & done_q) | (ovr_q & ~clr_ovr);
      tmo_q  <= timeout | (tmo_q & ~clr_tmo);
    end
  end

  assign INTcapt = ctrl_q[CTRL_IE] & (done_q | tmo_q);

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (PADDR)
        ADDR_CTRL:   PRDATA[3:0] = ctrl_q;
        ADDR_STATUS: PRDATA = {26'b0, state_q, 1'b0, tmo_q, ovr_q, done_q};
        ADDR_PERIOD: PRDATA = 32'(period_q);
        ADDR_HIGH:   PRDATA = 32'(high_q);
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capt.sv
// Scoreboard testbench for pwm_capt: APB reads are checked by a negedge monitor against a queue
// of expected values derived from the high/low durations the bench drives onto pwm_in.
module tb_pwm_capt;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 4;
`ifdef PWM_CAPT_FILTER_EN
  localparam int EDGE_LAT = SYNC_STAGES + 1 + FILT_LEN;
`else
  localparam int EDGE_LAT = SYNC_STAGES + 1;
`endif
  localparam int RD_WAIT = EDGE_LAT + 1;
  localparam int HOLD    = RD_WAIT + 8;

  logic        PCLK, PRESET, PSEL, PENABLE, PWRITE, pwm_in, INTcapt;
  logic [1:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t expQ[$];

  pwm_capt #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PADDR  (PADDR),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .pwm_in (pwm_in),
    .INTcapt(INTcapt)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every APB read access is a DUT output event; pop the matching expectation.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE && !PWRITE) begin
      exp_t e;
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_read: got 0x%08h, expected no read", PRDATA);
      end else begin
        e = expQ.pop_front();
        checkOutput(e.name, PRDATA, e.exp);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic level, input int n);
    pwm_in = level;
    cycles(n);
  endtask

  task automatic apbRead(input logic [1:0] addr, input string name, input logic [31:0] exp);
    exp_t e;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    cycles(1);
    PENABLE = 1'b1;
    e.name = name;
    e.exp  = exp;
    expQ.push_back(e);
    cycles(1);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apbWrite(input logic [1:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    cycles(1);
    PENABLE = 1'b1;
    cycles(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Takes exactly HOLD cycles so the caller knows how long pwm_in stayed at its level.
  task automatic readResults(input int expP, input int expH, input logic [31:0] expS,
                             input logic expInt, input logic clr);
    cycles(RD_WAIT);
    apbRead(2'd2, "period", 32'(expP));
    apbRead(2'd3, "high", 32'(expH));
    apbRead(2'd1, "status", expS);
    checkOutput("intcapt", {31'b0, INTcapt}, {31'b0, expInt});
    if (clr) apbWrite(2'd1, 32'h7);
    else     cycles(2);
  endtask

  task automatic checkAllZero(input string tag);
    apbRead(2'd0, {tag, "_ctrl"}, 32'h0);
    apbRead(2'd1, {tag, "_status"}, 32'h0);
    apbRead(2'd2, {tag, "_period"}, 32'h0);
    apbRead(2'd3, {tag, "_high"}, 32'h0);
    checkOutput({tag, "_int"}, {31'b0, INTcapt}, 32'h0);
    checkOutput({tag, "_prdata_idle"}, PRDATA, 32'h0);
  endtask

  initial begin
    int h, l, prevH, prevL;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PADDR = 2'd0; PWRITE = 1'b0;
    PWDATA = 32'h0; pwm_in = 1'b0;
    @(posedge PCLK);
    #1;
    cycles(3);
    PRESET = 1'b0;
    cycles(1);

    // Reset state.
    checkAllZero("rst");

    // Continuous 3/7 measurement, then overrun on an uncleared DONE.
    apbWrite(2'd0, 32'h3);
    applyStimulus(1'b0, 6);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 7);
    pwm_in = 1'b1;
    readResults(10, 3, 32'h21, 1'b1, 1'b0);
    applyStimulus(1'b0, 7);
    pwm_in = 1'b1;
    readResults(HOLD + 7, HOLD, 32'h23, 1'b1, 1'b1);
    checkOutput("int_after_clear", {31'b0, INTcapt}, 32'h0);

    // Single-shot 25/75.
    applyStimulus(1'b0, 6);
    apbWrite(2'd0, 32'h0);
    apbWrite(2'd1, 32'h7);
    apbWrite(2'd0, 32'h9);
    applyStimulus(1'b0, 6);
    applyStimulus(1'b1, 25);
    applyStimulus(1'b0, 75);
    pwm_in = 1'b1;
    readResults(100, 25, 32'h01, 1'b0, 1'b0);
    apbRead(2'd0, "ctrl_single", 32'h8);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 10);
    apbRead(2'd2, "period_single_hold", 32'd100);
    apbRead(2'd3, "high_single_hold", 32'd25);
    apbRead(2'd1, "status_single_hold", 32'h01);

    // Timeout with pwm_in stuck high.
    applyStimulus(1'b0, 6);
    apbWrite(2'd1, 32'h7);
    apbWrite(2'd0, 32'h3);
    applyStimulus(1'b0, 6);
    pwm_in = 1'b1;
    cycles(250);
    apbRead(2'd1, "status_pre_tmo", 32'h20);
    cycles(20);
    apbRead(2'd1, "status_tmo", 32'h14);
    apbRead(2'd2, "period_tmo", 32'd100);
    apbRead(2'd3, "high_tmo", 32'd25);
    checkOutput("int_tmo", {31'b0, INTcapt}, 32'h1);
    apbWrite(2'd1, 32'h4);
    apbRead(2'd1, "status_tmo_clr", 32'h10);

    // W1C of DONE in the same cycle as a completion.
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, HOLD);
    applyStimulus(1'b0, 10);
    pwm_in = 1'b1;
    readResults(HOLD + 10, HOLD, 32'h21, 1'b1, 1'b0);
    applyStimulus(1'b0, 14);
    pwm_in = 1'b1;
    cycles(EDGE_LAT - 2);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 2'd1; PWDATA = 32'h1; PENABLE = 1'b0;
    cycles(1);
    PENABLE = 1'b1;
    cycles(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    readResults(HOLD + 14, HOLD, 32'h23, 1'b1, 1'b1);

    // EN cleared mid-measurement.
    applyStimulus(1'b0, RD_WAIT);
    apbWrite(2'd0, 32'h2);
    apbRead(2'd1, "status_disabled", 32'h00);
    apbRead(2'd2, "period_disabled", 32'(HOLD + 14));
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 10);
    apbRead(2'd2, "period_disabled2", 32'(HOLD + 14));
    apbRead(2'd3, "high_disabled2", 32'(HOLD));
    apbRead(2'd1, "status_disabled2", 32'h00);

    // Randomized waveform; each period's result is read during the following high phase.
    applyStimulus(1'b0, 6);
    apbWrite(2'd1, 32'h7);
    apbWrite(2'd0, 32'h3);
    applyStimulus(1'b0, 6);
    prevH = 0;
    prevL = 0;
    for (int i = 0; i < 10; i++) begin
      h = HOLD + int'($urandom_range(20, 0));
      l = int'($urandom_range(40, 6));
      pwm_in = 1'b1;
      if (i > 0) readResults(prevH + prevL, prevH, 32'h21, 1'b1, 1'b1);
      else       cycles(HOLD);
      cycles(h - HOLD);
      applyStimulus(1'b0, l);
      prevH = h;
      prevL = l;
    end
    pwm_in = 1'b1;
    readResults(prevH + prevL, prevH, 32'h21, 1'b1, 1'b1);

    // Reset in the middle of a measurement.
    applyStimulus(1'b0, 5);
    PRESET = 1'b1;
    cycles(1);
    PRESET = 1'b0;
    checkAllZero("midrst");

`ifdef PWM_CAPT_FILTER_EN
    // 10/10 waveform with 2-cycle glitches in both phases.
    apbWrite(2'd0, 32'h3);
    applyStimulus(1'b0, 10);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b1, 4);
      applyStimulus(1'b0, 2);
      applyStimulus(1'b1, 4);
      applyStimulus(1'b0, 4);
      applyStimulus(1'b1, 2);
      applyStimulus(1'b0, 4);
    end
    pwm_in = 1'b1;
    readResults(20, 10, 32'h23, 1'b1, 1'b1);
`endif

    cycles(5);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
